// File: rtl/adc_conv_pkg.sv
// rtl/adc_conv_pkg.sv - shared state encoding, default parameters and counter-width helpers for the SAR engine
package adc_conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } conv_state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_SAMPLE_CYC = 4;
    localparam int DEF_SETTLE_CYC = 1;

    // Bits needed to hold any value 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_IDX_W    = cnt_w(DEF_DATA_W - 1);
    localparam int DEF_SMP_W    = cnt_w(DEF_SAMPLE_CYC - 1);
    localparam int DEF_SETTLE_W = cnt_w(DEF_SETTLE_CYC);

endpackage

// File: rtl/adc_sar_bit_reg.sv
// rtl/adc_sar_bit_reg.sv - SAR result register, bit index and registered DAC trial code
module adc_sar_bit_reg
    import adc_conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load,
    input  logic              step,
    input  logic              clear,
    input  logic              comp,
    output logic [DATA_W-1:0] code,
    output logic [DATA_W-1:0] kept,
    output logic              last
);

    localparam int IDX_W = cnt_w(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] result;
    logic [IDX_W-1:0]  idx;

    // code always equals result | (1 << idx) while converting, so keeping the bit is just taking code
    assign kept = comp ? code : result;
    assign last = (idx == '0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            result <= '0;
            idx    <= '0;
            code   <= '0;
        end else if (clear) begin
            code <= '0;
        end else if (load) begin
            result <= '0;
            idx    <= IDX_W'(DATA_W - 1);
            code   <= ONE << (DATA_W - 1);
        end else if (step) begin
            result <= kept;
            if (last) begin
                code <= '0;
            end else begin
                idx  <= idx - 1'b1;
                code <= kept | (ONE << (idx - 1'b1));
            end
        end
    end

endmodule

// File: rtl/adc_sar_conv_engine.sv
// rtl/adc_sar_conv_engine.sv - successive-approximation conversion engine answering the ADC sequencer
module adc_sar_conv_engine
    import adc_conv_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              conv_en_in,
    input  logic              soc_in,
    input  logic              comp_in,
    output logic              sample_out,
    output logic [DATA_W-1:0] dac_code_out,
    output logic              busy_out,
    output logic              eoc_out,
    output logic [DATA_W-1:0] data_out,
    output logic              soc_miss_out
);

    localparam int SMP_W = cnt_w(SAMPLE_CYC - 1);
    localparam int SET_W = cnt_w(SETTLE_CYC);

    conv_state_t       state;
    conv_state_t       state_next;
    logic [SMP_W-1:0]  smp_cnt;
    logic [SET_W-1:0]  set_cnt;
    logic              bit_load;
    logic              bit_step;
    logic              bit_clear;
    logic              bit_last;
    logic [DATA_W-1:0] kept;

    always_comb begin
        state_next = state;
        bit_load   = 1'b0;
        bit_step   = 1'b0;
        bit_clear  = !conv_en_in;
        case (state)
            IDLE: begin
                if (conv_en_in && soc_in) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (!conv_en_in) begin
                    state_next = IDLE;
                end else if (smp_cnt == '0) begin
                    state_next = CONVERT;
                    bit_load   = 1'b1;
                end
            end
            CONVERT: begin
                // abort wins over the final bit, which suppresses that EOC
                if (!conv_en_in) begin
                    state_next = IDLE;
                end else if (set_cnt == '0) begin
                    bit_step = 1'b1;
                    if (bit_last) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            smp_cnt <= '0;
            set_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                smp_cnt <= SMP_W'(SAMPLE_CYC - 1);
            end else if (state == SAMPLE && smp_cnt != '0) begin
                smp_cnt <= smp_cnt - 1'b1;
            end
            if (state != CONVERT || set_cnt == '0) begin
                set_cnt <= SET_W'(SETTLE_CYC);
            end else begin
                set_cnt <= set_cnt - 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sample_out   <= 1'b0;
            busy_out     <= 1'b0;
            eoc_out      <= 1'b0;
            soc_miss_out <= 1'b0;
            data_out     <= '0;
        end else begin
            sample_out   <= (state_next == SAMPLE);
            busy_out     <= (state_next != IDLE);
            eoc_out      <= (state_next == DONE);
            soc_miss_out <= (state != IDLE) && soc_in && conv_en_in;
            if (state_next == DONE) data_out <= kept;
        end
    end

    adc_sar_bit_reg #(
        .DATA_W(DATA_W)
    ) u_bit_reg (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .load  (bit_load),
        .step  (bit_step),
        .clear (bit_clear),
        .comp  (comp_in),
        .code  (dac_code_out),
        .kept  (kept),
        .last  (bit_last)
    );

endmodule

// File: tb/tb_adc_sar_conv_engine.sv
// tb/tb_adc_sar_conv_engine.sv - scoreboard bench for the SAR conversion engine at default parameters
module tb_adc_sar_conv_engine;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        conv_en_in = 1'b0;
    logic        soc_in = 1'b0;
    logic        comp_in;
    logic        sample_out;
    logic [11:0] dac_code_out;
    logic        busy_out;
    logic        eoc_out;
    logic [11:0] data_out;
    logic        soc_miss_out;
    logic [11:0] vin = 12'h000;

    adc_sar_conv_engine dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .conv_en_in  (conv_en_in),
        .soc_in      (soc_in),
        .comp_in     (comp_in),
        .sample_out  (sample_out),
        .dac_code_out(dac_code_out),
        .busy_out    (busy_out),
        .eoc_out     (eoc_out),
        .data_out    (data_out),
        .soc_miss_out(soc_miss_out)
    );

    assign comp_in = (vin >= dac_code_out);

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [11:0] last_data = 12'h000;

    task automatic check_val(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (eoc_out) begin
            if (sb.size() == 0) begin
                check_val("eoc_unexpected", int'(eoc_out), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("eoc_cycle", cyc, e.cyc);
                check_val("eoc_data", int'(data_out), e.data);
            end
        end
    end

    // One SOC at relative cycle 0; m1/m2 are extra SOC cycles while busy, ab the abort cycle (negative = none).
    task automatic do_conv(input logic [11:0] v, input int m1, input int m2, input int ab);
        int c0;
        int r;
        bit live;
        @(posedge clk_in);
        #1;
        c0 = cyc;
        vin = v;
        conv_en_in = 1'b1;
        soc_in = 1'b1;
        if (ab < 0) sb.push_back('{c0 + 29, int'(v)});
        for (int i = 0; i < 34; i++) begin
            @(negedge clk_in);
            r = cyc - c0;
            live = (ab < 0) || (r <= ab);
            check_val("sample", int'(sample_out), int'(live && r >= 1 && r <= 4));
            check_val("busy", int'(busy_out), int'(live && r >= 1 && r <= 29));
            check_val("soc_miss", int'(soc_miss_out), int'(live && (r == m1 + 1 || r == m2 + 1)));
            if (!live) check_val("dac_idle", int'(dac_code_out), 0);
            else if (r == 5 || r == 6) check_val("dac_msb", int'(dac_code_out), 'h800);
            else if (r == 28) check_val("dac_lsb", int'(dac_code_out), int'(v) | 1);
            soc_in = (r == 0) || (r == m1) || (r == m2);
            if (r == ab) conv_en_in = 1'b0;
        end
        soc_in = 1'b0;
        conv_en_in = 1'b1;
        if (ab < 0) last_data = v;
        check_val("data_out", int'(data_out), int'(last_data));
    endtask

    task automatic hold_soc();
        int c0;
        int r;
        @(posedge clk_in);
        #1;
        c0 = cyc;
        vin = 12'h123;
        conv_en_in = 1'b1;
        soc_in = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{c0 + 29 + 30 * k, 'h123});
        for (int i = 0; i < 126; i++) begin
            @(negedge clk_in);
            r = cyc - c0;
            if (r == 30) check_val("hold_idle_gap", int'(busy_out), 0);
            if (r == 31) check_val("hold_resample", int'(sample_out), 1);
            if (r == 89) soc_in = 1'b0;
        end
        last_data = 12'h123;
        check_val("hold_data", int'(data_out), 'h123);
    endtask

    task automatic reset_mid_conv();
        int c0;
        int r;
        @(posedge clk_in);
        #1;
        c0 = cyc;
        vin = 12'h777;
        conv_en_in = 1'b1;
        soc_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_in);
            r = cyc - c0;
            if (r == 1) soc_in = 1'b0;
            if (r == 12) begin
                rst_in = 1'b0;
                #1;
                check_val("rst_busy", int'(busy_out), 0);
                check_val("rst_sample", int'(sample_out), 0);
                check_val("rst_dac", int'(dac_code_out), 0);
                check_val("rst_data", int'(data_out), 0);
                check_val("rst_eoc", int'(eoc_out), 0);
                check_val("rst_miss", int'(soc_miss_out), 0);
            end
            if (r == 14) rst_in = 1'b1;
        end
        last_data = 12'h000;
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check_val("init_busy", int'(busy_out), 0);
        check_val("init_sample", int'(sample_out), 0);
        check_val("init_dac", int'(dac_code_out), 0);
        check_val("init_data", int'(data_out), 0);
        check_val("init_eoc", int'(eoc_out), 0);
        check_val("init_miss", int'(soc_miss_out), 0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        do_conv(12'hFFF, -9, -9, -1);
        do_conv(12'h000, -9, -9, -1);
        do_conv(12'hA5C, -9, -9, -1);
        do_conv(12'h3C3, -9, -9, 10);
        do_conv(12'h5A5, 3, 15, -1);
        hold_soc();
        reset_mid_conv();
        do_conv(12'h2B7, -9, -9, -1);

        repeat (5) @(negedge clk_in);
        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
